mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shared-memory arbiter and sequencer between the fetch stage and the load/store path of the RISC-V core. It owns the single unified memory port and models its fixed access latency. It grants one requester at a time with data-first priority and a starvation guard for fetch. It returns read data with a one-cycle valid pulse and exports a busy flag the control unit uses to hold the pipeline during a memory access.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_DELAY, 4, cycles from grant to response; legal range 1..15
- STARVE_MAX, 3, consecutive data grants allowed while fetch waits; legal range ≥1

Ports:
- clk  in  1  clock; all state on posedge
- nrst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard the outstanding fetch response (branch mispredict)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid / store complete
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the response cycle
- mem_busy  out  1  transaction in flight; fed to the control unit as a stall source

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D. Counter cnt is 4 bits. starve_cnt is saturating, width clog2(STARVE_MAX+1).
- IDLE: grants are combinational.
  - d_req & ~(if_req & starve_cnt==STARVE_MAX) → d_gnt=1 → BUSY_D.
  - Otherwise if_req → if_gnt=1 → BUSY_IF.
  - At most one gnt per cycle. gnt is never asserted outside IDLE.
- Grant edge:
  - Latch addr, we (0 for fetch) and wdata into the holding regs.
  - cnt←1.
  - Clear the flush_pending flag.
- starve_cnt update:
  - Data granted while if_req=1: starve_cnt+1, saturating.
  - Fetch granted: starve_cnt←0.
  - Data granted with if_req=0: starve_cnt←0.
- BUSY_x:
  - mem_en=1. mem_we/mem_addr/mem_wdata come from the holding regs.
  - cnt increments each cycle.
  - When cnt==MEM_DELAY (response cycle): owner rvalid=1, owner rdata=mem_rdata. Next state is IDLE.
- Idle-state outputs: mem_en=0, mem_we=0. Address and data outputs keep their last value.
- if_flush:
  - Asserted in BUSY_IF, including the response cycle: sets flush_pending, and if_rvalid is suppressed in the response cycle.
  - The memory cycle still runs to completion.
  - if_flush in IDLE or BUSY_D has no effect.
- d_rvalid is never suppressed.
- rdata outputs equal mem_rdata only while the corresponding rvalid=1. Otherwise they are 0.

## Timing
- Grant in cycle T. Busy cycles T+1..T+MEM_DELAY. rvalid at T+MEM_DELAY. IDLE at T+MEM_DELAY+1. Earliest next grant is T+MEM_DELAY+1.
- Throughput: one access per MEM_DELAY+1 cycles.
- mem_busy = (state != IDLE), registered. It is 0 in the grant cycle and 1 from T+1 to T+MEM_DELAY.
- A request arriving while busy waits. Its gnt comes in the first IDLE cycle.
- Simultaneous if_req and d_req in IDLE: data wins, unless starve_cnt==STARVE_MAX.
- Reset at any time:
  - state=IDLE, cnt=0, starve_cnt=0, flush_pending=0, holding regs=0.
  - All outputs 0.
  - An in-flight transaction is dropped with no rvalid.
- After nrst deasserts, the first grant can occur in the first rising-edge cycle.

## Test plan
- Reset check: hold nrst=0 mid-BUSY_D with MEM_DELAY=4 → all outputs 0 immediately. After release, no d_rvalid. An if_req at 0x100 is granted in the first cycle.
- Single load: d_req, d_addr=0x40, mem_rdata=0xDEADBEEF at cycle T+4 → d_gnt at T. mem_en=1 and mem_addr=0x40 for T+1..T+4. d_rvalid=1 and d_rdata=0xDEADBEEF at T+4 only. mem_busy=1 for T+1..T+4.
- Store: d_we=1, d_addr=0x80, d_wdata=0x12345678 → mem_we=1 with that address and data for 4 cycles. d_rvalid pulses at T+4.
- Contention and starvation, STARVE_MAX=3: if_req and d_req held continuously → grant order D, D, D, IF, D, D, D, IF. Grants are spaced 5 cycles apart.
- Flush: fetch granted at T, if_flush pulsed at T+2 → no if_rvalid at T+4. mem_en stays high through T+4. The next if_req is granted at T+5 and its response is delivered normally.
- Back-to-back: d_req asserted during BUSY_IF → d_gnt at exactly T+MEM_DELAY+1, never earlier.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: owns the unified memory port and arbitrates between fetch and load/store
// with data-first priority, a fetch starvation guard and a fixed access latency.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_DELAY  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic              flush_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              idle;
    logic              resp;
    logic              starved;

    assign idle    = state_q == IDLE;
    assign resp    = !idle && cnt_q == 4'(MEM_DELAY);
    assign starved = starve_q == SW'(STARVE_MAX);

    // Grants are combinational but gated by nrst so every output is 0 while in reset.
    assign d_gnt  = nrst && idle && d_req && !(if_req && starved);
    assign if_gnt = nrst && idle && if_req && !d_gnt;

    assign if_rvalid = resp && state_q == BUSY_IF && !flush_q && !if_flush;
    assign d_rvalid  = resp && state_q == BUSY_D;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign mem_en    = !idle;
    assign mem_we    = !idle && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_busy  = !idle;

    assign starve_d = (if_gnt || !if_req) ? '0 : starved ? starve_q : starve_q + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            flush_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (d_gnt || if_gnt) begin
            state_q  <= d_gnt ? BUSY_D : BUSY_IF;
            cnt_q    <= 4'd1;
            starve_q <= starve_d;
            flush_q  <= 1'b0;
            we_q     <= d_gnt && d_we;
            addr_q   <= d_gnt ? d_addr : if_addr;
            wdata_q  <= d_gnt ? d_wdata : wdata_q;
        end else if (!idle) begin
            cnt_q   <= cnt_q + 4'd1;
            state_q <= resp ? IDLE : state_q;
            flush_q <= flush_q || (state_q == BUSY_IF && if_flush);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a timestamp-based reference model checked every cycle
// plus hand-computed expectations for the key scenarios.
module tb_mem_port_arbiter;
    localparam int MD = 4;
    localparam int SM = 3;

    logic        clk = 0;
    logic        nrst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, mem_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DELAY(MD), .STARVE_MAX(SM)) dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    // Memory stand-in: data is a known function of the address, garbage when not enabled.
    assign mem_rdata = mem_en ? (mem_addr ^ 32'hDEADBEAF) : 32'h0BADF00D;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: remembers when and to whom the last grant went.
    bit          m_valid = 0, m_d = 0, m_we = 0, m_flush = 0;
    int          m_gcyc = 0, m_starve = 0, ph;
    logic [31:0] m_addr = 0, m_wdata = 0;
    bit          busy, resp, edg, eig, eifr, edr;

    always @(negedge clk) begin
        if (!nrst) begin
            m_valid = 0; m_starve = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_flush = 0;
        end
        ph   = cyc - m_gcyc;
        busy = nrst && m_valid && ph >= 1 && ph <= MD;
        resp = busy && ph == MD;
        edg  = nrst && !busy && d_req && !(if_req && m_starve == SM);
        eig  = nrst && !busy && if_req && !edg;
        eifr = resp && !m_d && !m_flush && !if_flush;
        edr  = resp && m_d;
        chk("d_gnt", 64'(d_gnt), 64'(edg));
        chk("if_gnt", 64'(if_gnt), 64'(eig));
        chk("if_rvalid", 64'(if_rvalid), 64'(eifr));
        chk("if_rdata", 64'(if_rdata), eifr ? 64'(m_addr ^ 32'hDEADBEAF) : 64'd0);
        chk("d_rvalid", 64'(d_rvalid), 64'(edr));
        chk("d_rdata", 64'(d_rdata), edr ? 64'(m_addr ^ 32'hDEADBEAF) : 64'd0);
        chk("mem_en", 64'(mem_en), 64'(busy));
        chk("mem_busy", 64'(mem_busy), 64'(busy));
        chk("mem_we", 64'(mem_we), 64'(busy && m_we));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (busy && m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        if (busy && !m_d && if_flush) m_flush = 1;
        if (edg || eig) begin
            m_valid = 1; m_gcyc = cyc; m_d = edg; m_flush = 0;
            m_addr  = edg ? d_addr : if_addr;
            m_we    = edg && d_we;
            if (edg) m_wdata = d_wdata;
            m_starve = (eig || !if_req) ? 0 : (m_starve < SM ? m_starve + 1 : SM);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // mode 0: fetch grant, 1: data grant, 2: either. Returns at posedge+1 after the grant edge.
    task automatic wait_gnt(input int mode, output bit was_d, output int gt);
        int n = 0;
        @(negedge clk);
        while (!(mode == 0 ? if_gnt : mode == 1 ? d_gnt : (if_gnt || d_gnt)) && n < 60) begin
            @(negedge clk);
            n++;
        end
        was_d = d_gnt;
        gt = cyc;
        chk("gnt_timeout", 64'(n < 60), 64'd1);
        step();
    endtask

    bit          wd;
    int          t, t2;
    bit          g_d[8];
    int          g_t[8];
    logic [7:0]  ord_exp = 8'b0111_0111;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nrst = 0; if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        @(negedge clk);
        chk("rst_en", 64'(mem_en), 64'd0);
        chk("rst_busy", 64'(mem_busy), 64'd0);
        step();
        nrst = 1;
        // single load
        d_req = 1; d_addr = 32'h40;
        wait_gnt(1, wd, t);
        d_req = 0;
        @(negedge clk);
        chk("ld_busy", 64'(mem_busy), 64'd1);
        chk("ld_addr", 64'(mem_addr), 64'h40);
        repeat (2) @(negedge clk);
        chk("ld_early", 64'(d_rvalid), 64'd0);
        @(negedge clk);
        chk("ld_rv", 64'(d_rvalid), 64'd1);
        chk("ld_rdata", 64'(d_rdata), 64'hDEADBEEF);
        chk("ld_cyc", 64'(cyc), 64'(t + 4));
        @(negedge clk);
        chk("ld_done", 64'(mem_busy), 64'd0);
        chk("ld_rv_off", 64'(d_rvalid), 64'd0);
        // store, with a flush during BUSY_D that must do nothing
        step();
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678;
        wait_gnt(1, wd, t);
        d_req = 0; d_we = 0; if_flush = 1;
        @(negedge clk);
        chk("st_we", 64'(mem_we), 64'd1);
        chk("st_wdata", 64'(mem_wdata), 64'h12345678);
        chk("st_addr", 64'(mem_addr), 64'h80);
        step();
        if_flush = 0;
        repeat (3) @(negedge clk);
        chk("st_rv", 64'(d_rvalid), 64'd1);
        chk("st_we_last", 64'(mem_we), 64'd1);
        // flush while idle: no effect on the following fetch
        step();
        if_flush = 1;
        step();
        if_flush = 0;
        // contention with starvation guard
        if_req = 1; if_addr = 32'h100; d_req = 1; d_addr = 32'h200;
        for (int i = 0; i < 8; i++) wait_gnt(2, g_d[i], g_t[i]);
        if_req = 0; d_req = 0;
        for (int i = 0; i < 8; i++) begin
            chk("cont_order", 64'(g_d[i]), 64'(ord_exp[i]));
            if (i > 0) chk("cont_spacing", 64'(g_t[i] - g_t[i-1]), 64'd5);
        end
        // flush mid-fetch
        if_req = 1; if_addr = 32'h300;
        wait_gnt(0, wd, t);
        if_req = 0;
        step();
        if_flush = 1;
        step();
        if_flush = 0;
        repeat (2) @(negedge clk);
        chk("fl_rv", 64'(if_rvalid), 64'd0);
        chk("fl_en", 64'(mem_en), 64'd1);
        step();
        if_req = 1; if_addr = 32'h304;
        wait_gnt(0, wd, t2);
        if_req = 0;
        chk("fl_next_gnt", 64'(t2), 64'(t + 5));
        repeat (4) @(negedge clk);
        chk("fl_next_rv", 64'(if_rvalid), 64'd1);
        chk("fl_next_rdata", 64'(if_rdata), 64'hDEADBDAB);
        // flush in the response cycle
        step();
        if_req = 1; if_addr = 32'h308;
        wait_gnt(0, wd, t);
        if_req = 0;
        repeat (3) step();
        if_flush = 1;
        @(negedge clk);
        chk("fl_resp_rv", 64'(if_rvalid), 64'd0);
        step();
        if_flush = 0;
        // data request arriving during BUSY_IF
        if_req = 1; if_addr = 32'h400;
        wait_gnt(0, wd, t);
        if_req = 0;
        step();
        d_req = 1; d_addr = 32'h44;
        wait_gnt(1, wd, t2);
        d_req = 0;
        chk("b2b_gnt", 64'(t2), 64'(t + MD + 1));
        // reset mid-load
        step();
        nrst = 0; if_req = 1; if_addr = 32'h100;
        #1;
        chk("rst_mid_en", 64'(mem_en), 64'd0);
        chk("rst_mid_busy", 64'(mem_busy), 64'd0);
        chk("rst_mid_ignt", 64'(if_gnt), 64'd0);
        chk("rst_mid_addr", 64'(mem_addr), 64'd0);
        step();
        nrst = 1;
        @(negedge clk);
        chk("rst_first_gnt", 64'(if_gnt), 64'd1);
        step();
        if_req = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_drv", 64'(d_rvalid), 64'd0);
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
